temperature_scan_ctrl: RTL and testbench

//  Sequential controller for the temperature-monitoring datapath: scans WIDTH sensors one per cycle

---
 rtl/temperature_pkg.sv | 16 +
 rtl/temperature_scan_ctrl_if.sv | 28 ++
 rtl/temperature_seq_div.sv | 60 ++++++
 rtl/temperature_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_temperature_scan_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/temperature_pkg.sv
// Shared types and widths for the temperature scan controller and its serial divider.
package temperature_pkg;

  localparam int SUM_W      = 16;
  localparam int CNT_W      = 8;
  localparam int TEMP_W     = 8;
  localparam int DIV_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/temperature_scan_ctrl_if.sv
// Sensor mux / control bus of temperature_scan_ctrl; master is the controller, slave the environment.
interface temperature_scan_ctrl_if;
  import temperature_pkg::*;

  // start_i is a request level sampled only while IDLE (never queued); done_o is a one-cycle
  // completion pulse, results stay valid from that cycle until the next done_o or reset.
  logic              start_i;
  logic [TEMP_W-1:0] sensor_sel_o;
  logic [TEMP_W-1:0] sensor_data_i;
  logic              sensor_en_i;
  logic              busy_o;
  logic              done_o;
  logic [TEMP_W-1:0] led_output_o;
  logic              alert_o;
  logic [CNT_W-1:0]  nr_active_o;
  state_e            dbg_state_o;

  modport master (
    input  start_i, sensor_data_i, sensor_en_i,
    output sensor_sel_o, busy_o, done_o, led_output_o, alert_o, nr_active_o, dbg_state_o
  );

  modport slave (
    output start_i, sensor_data_i, sensor_en_i,
    input  sensor_sel_o, busy_o, done_o, led_output_o, alert_o, nr_active_o, dbg_state_o
  );

endinterface

// File: rtl/temperature_seq_div.sv
// 16/16 restoring divider: one quotient bit per cycle, busy from start until the done cycle.
module temperature_seq_div
  import temperature_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [SUM_W-1:0] dividend_i,
  input  logic [SUM_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [SUM_W-1:0] quotient_o,
  output logic [SUM_W-1:0] remainder_o
);

  logic             r_busy;
  logic [3:0]       r_step;
  logic [SUM_W-1:0] r_rem;
  logic [SUM_W-1:0] r_quot;
  logic [SUM_W-1:0] r_div;
  logic [SUM_W:0]   w_shift;
  logic [SUM_W:0]   w_diff;

  // Partial remainder is always below the divisor, so the shifted value fits in SUM_W+1 bits
  // and bit SUM_W of the difference is the borrow.
  assign w_shift = {r_rem, r_quot[SUM_W-1]};
  assign w_diff  = w_shift - {1'b0, r_div};

  assign busy_o      = r_busy;
  assign done_o      = r_busy && (r_step == 4'(DIV_CYCLES - 1));
  assign quotient_o  = r_quot;
  assign remainder_o = r_rem;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy <= 1'b0;
      r_step <= '0;
      r_rem  <= '0;
      r_quot <= '0;
      r_div  <= '0;
    end else if (start_i) begin
      r_busy <= 1'b1;
      r_step <= '0;
      r_rem  <= '0;
      r_quot <= dividend_i;
      r_div  <= divisor_i;
    end else if (r_busy) begin
      if (w_diff[SUM_W]) begin
        r_rem  <= w_shift[SUM_W-1:0];
        r_quot <= {r_quot[SUM_W-2:0], 1'b0};
      end else begin
        r_rem  <= w_diff[SUM_W-1:0];
        r_quot <= {r_quot[SUM_W-2:0], 1'b1};
      end
      r_step <= r_step + 4'd1;
      if (done_o) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/temperature_scan_ctrl.sv
// Sequential temperature scan: one sensor per cycle, serial average, registered average/alert.
// Optional automatic rescan every PERIOD idle cycles when TEMP_SCAN_PERIODIC_EN is defined.
module temperature_scan_ctrl
  import temperature_pkg::*;
#(
  parameter int WIDTH    = 200,
  parameter int TEMP_MIN = 19,
  parameter int TEMP_MAX = 26,
  parameter int PERIOD   = 1000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  temperature_scan_ctrl_if.master bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [TEMP_W-1:0] T_MIN    = TEMP_W'(TEMP_MIN);
  localparam logic [TEMP_W-1:0] T_MAX    = TEMP_W'(TEMP_MAX);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_idx;
  logic [SUM_W-1:0]  r_sum;
  logic [CNT_W-1:0]  r_cnt;
  logic [TEMP_W-1:0] r_led;
  logic              r_alert;
  logic [CNT_W-1:0]  r_nr;
  logic              r_done;

  logic              w_go;
  logic              w_last;
  logic [SUM_W-1:0]  w_sum_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_div_start;
  logic              w_div_busy;
  logic              w_div_done;
  logic [SUM_W-1:0]  w_quot;
  logic [SUM_W-1:0]  w_rem;
  logic [TEMP_W-1:0] w_avg;
  logic              w_unused_div;

  assign w_last      = (r_idx == LAST_IDX);
  assign w_sum_next  = r_sum + (bus.sensor_en_i ? {{(SUM_W-TEMP_W){1'b0}}, bus.sensor_data_i} : '0);
  assign w_cnt_next  = r_cnt + {{(CNT_W-1){1'b0}}, bus.sensor_en_i};
  // The divider is fed the accumulators including the last sensor, so DIV needs no extra cycle.
  assign w_div_start = (r_state == ST_SCAN) && w_last && (w_cnt_next != '0);
  assign w_avg       = w_quot[TEMP_W-1:0];
  assign w_unused_div = ^{w_rem, w_quot[SUM_W-1:TEMP_W], w_div_busy};

`ifdef TEMP_SCAN_PERIODIC_EN
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD - 1);

  logic [PW-1:0] r_idle_cnt;
  logic          w_period_hit;

  assign w_period_hit = (r_state == ST_IDLE) && (r_idle_cnt == PERIOD_LAST);
  assign w_go         = bus.start_i || w_period_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i || (r_state != ST_IDLE) || w_go) r_idle_cnt <= '0;
    else                                       r_idle_cnt <= r_idle_cnt + PW'(1);
  end
`else
  logic w_unused_period;
  assign w_unused_period = |PERIOD;
  assign w_go            = bus.start_i;
`endif

  temperature_seq_div u_div (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (w_div_start),
    .dividend_i  (w_sum_next),
    .divisor_i   ({{(SUM_W-CNT_W){1'b0}}, w_cnt_next}),
    .busy_o      (w_div_busy),
    .done_o      (w_div_done),
    .quotient_o  (w_quot),
    .remainder_o (w_rem)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_led   <= '0;
      r_alert <= 1'b0;
      r_nr    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            r_state <= ST_SCAN;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
          end
        end
        ST_SCAN: begin
          r_sum <= w_sum_next;
          r_cnt <= w_cnt_next;
          r_idx <= r_idx + CNT_W'(1);
          if (w_last) begin
            r_idx   <= '0;
            r_state <= (w_cnt_next != '0) ? ST_DIV : ST_DONE;
          end
        end
        ST_DIV: begin
          if (w_div_done) r_state <= ST_DONE;
        end
        default: begin
          r_done  <= 1'b1;
          r_nr    <= r_cnt;
          // With no active sensor the divider never ran; report zero and raise the alert.
          if (r_cnt == '0) begin
            r_led   <= '0;
            r_alert <= 1'b1;
          end else begin
            r_led   <= w_avg;
            r_alert <= (w_avg < T_MIN) || (w_avg > T_MAX);
          end
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.sensor_sel_o = (r_state == ST_SCAN) ? r_idx : '0;
  assign bus.busy_o       = (r_state != ST_IDLE);
  assign bus.done_o       = r_done;
  assign bus.led_output_o = r_led;
  assign bus.alert_o      = r_alert;
  assign bus.nr_active_o  = r_nr;
  assign bus.dbg_state_o  = state_e'(r_state);

endmodule

// File: tb/tb_temperature_scan_ctrl.sv
// Self-checking bench for temperature_scan_ctrl (WIDTH=4 and WIDTH=200 instances).
module tb_temperature_scan_ctrl;
  import temperature_pkg::*;

  localparam int W    = 4;
  localparam int W2   = 200;
  localparam int TMIN = 19;
  localparam int TMAX = 26;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] d4   [256];
  logic       e4   [256];
  logic [7:0] d200 [256];
  logic       e200 [256];
  logic [24:0] exp_q[$];

  always #5 clk = ~clk;

  temperature_scan_ctrl_if if4();
  temperature_scan_ctrl_if if200();

  assign if4.sensor_data_i   = d4[if4.sensor_sel_o];
  assign if4.sensor_en_i     = e4[if4.sensor_sel_o];
  assign if200.sensor_data_i = d200[if200.sensor_sel_o];
  assign if200.sensor_en_i   = e200[if200.sensor_sel_o];

  temperature_scan_ctrl #(.WIDTH(W), .TEMP_MIN(TMIN), .TEMP_MAX(TMAX), .PERIOD(5000)) dut4 (
    .clk_i (clk), .rst_i (rst), .bus (if4)
  );

  temperature_scan_ctrl #(.WIDTH(W2), .TEMP_MIN(TMIN), .TEMP_MAX(TMAX), .PERIOD(5000)) dut200 (
    .clk_i (clk), .rst_i (rst), .bus (if200)
  );

`ifdef TEMP_SCAN_PERIODIC_EN
  temperature_scan_ctrl_if ifp();
  assign ifp.sensor_data_i = d4[ifp.sensor_sel_o];
  assign ifp.sensor_en_i   = e4[ifp.sensor_sel_o];
  assign ifp.start_i       = 1'b0;
  temperature_scan_ctrl #(.WIDTH(W), .TEMP_MIN(TMIN), .TEMP_MAX(TMAX), .PERIOD(10)) dutp (
    .clk_i (clk), .rst_i (rst), .bus (ifp)
  );
`endif

  // Reference: average of enabled sensors, alert window, and scan latency from the start edge.
  function automatic logic [24:0] model4();
    int sum = 0;
    int cnt = 0;
    int avg = 0;
    logic alert;
    int lat;
    for (int i = 0; i < W; i++) begin
      if (e4[i]) begin
        sum += d4[i];
        cnt++;
      end
    end
    if (cnt != 0) avg = sum / cnt;
    alert = (cnt == 0) || (avg < TMIN) || (avg > TMAX);
    lat   = (cnt == 0) ? W + 1 : W + 17;
    return {8'(lat), 8'(avg), alert, 8'(cnt)};
  endfunction

  task automatic set4(input int a0, a1, a2, a3, input logic [3:0] en);
    d4[0] = 8'(a0); d4[1] = 8'(a1); d4[2] = 8'(a2); d4[3] = 8'(a3);
    for (int i = 0; i < W; i++) e4[i] = en[i];
  endtask

  task automatic run_scan4(output int lat);
    @(negedge clk);
    if4.start_i = 1'b1;
    @(posedge clk);
    #1;
    if4.start_i = 1'b0;
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      if (if4.done_o) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    total++;
    if ({if4.sensor_sel_o, if4.busy_o, if4.done_o, if4.led_output_o, if4.alert_o, if4.nr_active_o} !== 27'd0) begin
      bad++;
      $display("FAIL reset_outputs4 got sel=%0d busy=%0b done=%0b led=%0d alert=%0b nr=%0d want all 0",
               if4.sensor_sel_o, if4.busy_o, if4.done_o, if4.led_output_o, if4.alert_o, if4.nr_active_o);
    end
    total++;
    if (if4.dbg_state_o !== IDLE) begin
      bad++;
      $display("FAIL reset_state got %0d want %0d", if4.dbg_state_o, IDLE);
    end
    total++;
    if ({if200.busy_o, if200.done_o, if200.led_output_o, if200.alert_o, if200.nr_active_o} !== 19'd0) begin
      bad++;
      $display("FAIL reset_outputs200 got busy=%0b led=%0d alert=%0b nr=%0d want all 0",
               if200.busy_o, if200.led_output_o, if200.alert_o, if200.nr_active_o);
    end
  endtask

  task automatic test_directed();
    int lat;
    logic [24:0] obs;
    logic [24:0] want [4];
    want[0] = {8'd21, 8'd25, 1'b0, 8'd4};
    want[1] = {8'd5,  8'd0,  1'b1, 8'd0};
    want[2] = {8'd21, 8'd25, 1'b0, 8'd2};
    want[3] = {8'd21, 8'd10, 1'b1, 8'd2};
    for (int t = 0; t < 4; t++) begin
      case (t)
        0:       set4(25, 25, 25, 25, 4'b1111);
        1:       set4(25, 25, 25, 25, 4'b0000);
        2:       set4(30, 20, 99, 99, 4'b0011);
        default: set4(10, 11, 99, 99, 4'b0011);
      endcase
      run_scan4(lat);
      obs = {8'(lat), if4.led_output_o, if4.alert_o, if4.nr_active_o};
      total++;
      if (obs !== want[t]) begin
        bad++;
        $display("FAIL directed_%0d got lat=%0d led=%0d alert=%0b nr=%0d want lat=%0d led=%0d alert=%0b nr=%0d",
                 t, lat, obs[16:9], obs[8], obs[7:0], want[t][24:17], want[t][16:9], want[t][8], want[t][7:0]);
      end
      @(posedge clk);
      #1;
      total++;
      if (if4.done_o !== 1'b0 || if4.led_output_o !== want[t][16:9]) begin
        bad++;
        $display("FAIL directed_hold_%0d got done=%0b led=%0d want done=0 led=%0d",
                 t, if4.done_o, if4.led_output_o, want[t][16:9]);
      end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [24:0] obs;
    logic [24:0] exp_v;
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < W; i++) begin
        d4[i] = 8'($urandom_range(n < 5 ? 15 : 0, n < 5 ? 30 : 255));
        e4[i] = 1'($urandom_range(0, 3) != 0);
      end
      exp_q.push_back(model4());
      run_scan4(lat);
      obs   = {8'(lat), if4.led_output_o, if4.alert_o, if4.nr_active_o};
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL random_%0d got lat=%0d led=%0d alert=%0b nr=%0d want lat=%0d led=%0d alert=%0b nr=%0d",
                 n, lat, obs[16:9], obs[8], obs[7:0], exp_v[24:17], exp_v[16:9], exp_v[8], exp_v[7:0]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat = -1;
    int extra = 0;
    set4(20, 22, 24, 26, 4'b1111);
    @(negedge clk);
    if4.start_i = 1'b1;
    @(posedge clk);
    #1;
    if4.start_i = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      if (k == 2 || k == 10) if4.start_i = 1'b1;
      @(posedge clk);
      #1;
      if4.start_i = 1'b0;
      if (if4.done_o) begin
        lat = k;
        break;
      end
    end
    total++;
    if (lat != 21 || if4.led_output_o !== 8'd23) begin
      bad++;
      $display("FAIL ignore_start got lat=%0d led=%0d want lat=21 led=23", lat, if4.led_output_o);
    end
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (if4.busy_o || if4.done_o) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL ignore_start_queued got %0d busy/done cycles want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int second = -1;
    set4(18, 18, 18, 18, 4'b1111);
    @(negedge clk);
    if4.start_i = 1'b1;
    for (int k = 0; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (if4.done_o) begin
        if (first < 0) begin
          first = k;
          set4(27, 28, 0, 0, 4'b0011);
        end else begin
          second = k;
          break;
        end
      end
    end
    if4.start_i = 1'b0;
    total++;
    if (first != 21 || second != 43) begin
      bad++;
      $display("FAIL back_to_back_timing got done at %0d,%0d want 21,43", first, second);
    end
    total++;
    if ({if4.led_output_o, if4.alert_o, if4.nr_active_o} !== {8'd27, 1'b1, 8'd2}) begin
      bad++;
      $display("FAIL back_to_back_result got led=%0d alert=%0b nr=%0d want led=27 alert=1 nr=2",
               if4.led_output_o, if4.alert_o, if4.nr_active_o);
    end
    repeat (30) @(posedge clk);
  endtask

  task automatic test_reset_mid_div();
    int spurious = 0;
    set4(21, 21, 21, 21, 4'b1111);
    @(negedge clk);
    if4.start_i = 1'b1;
    @(posedge clk);
    #1;
    if4.start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (if4.dbg_state_o !== DIV || if4.led_output_o === 8'd0) begin
      bad++;
      $display("FAIL pre_reset_div got state=%0d led=%0d want state=%0d led nonzero",
               if4.dbg_state_o, if4.led_output_o, DIV);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({if4.sensor_sel_o, if4.busy_o, if4.done_o, if4.led_output_o, if4.alert_o, if4.nr_active_o} !== 27'd0) begin
      bad++;
      $display("FAIL reset_mid_div got busy=%0b done=%0b led=%0d alert=%0b nr=%0d want all 0",
               if4.busy_o, if4.done_o, if4.led_output_o, if4.alert_o, if4.nr_active_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (if4.done_o || if4.busy_o) spurious++;
    end
    total++;
    if (spurious != 0) begin
      bad++;
      $display("FAIL reset_abort got %0d busy/done cycles want 0", spurious);
    end
  endtask

  task automatic test_wide();
    int lat = -1;
    for (int i = 0; i < W2; i++) begin
      d200[i] = 8'd255;
      e200[i] = 1'b1;
    end
    @(negedge clk);
    if200.start_i = 1'b1;
    @(posedge clk);
    #1;
    if200.start_i = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      #1;
      if (if200.done_o) begin
        lat = k;
        break;
      end
    end
    total++;
    if (lat != W2 + 17 || {if200.led_output_o, if200.alert_o, if200.nr_active_o} !== {8'd255, 1'b1, 8'd200}) begin
      bad++;
      $display("FAIL wide_all_255 got lat=%0d led=%0d alert=%0b nr=%0d want lat=%0d led=255 alert=1 nr=200",
               lat, if200.led_output_o, if200.alert_o, if200.nr_active_o, W2 + 17);
    end
  endtask

`ifdef TEMP_SCAN_PERIODIC_EN
  task automatic test_periodic();
    int last = -1;
    int seen = 0;
    int gaps_bad = 0;
    set4(25, 25, 25, 25, 4'b1111);
    for (int k = 0; k < 200 && seen < 3; k++) begin
      @(posedge clk);
      #1;
      if (ifp.done_o) begin
        if (last >= 0 && k - last != 31) gaps_bad++;
        last = k;
        seen++;
      end
    end
    total++;
    if (seen != 3 || gaps_bad != 0) begin
      bad++;
      $display("FAIL periodic got %0d scans, %0d wrong gaps want 3 scans 31 cycles apart", seen, gaps_bad);
    end
  endtask
`else
  task automatic test_no_auto_start();
    int busy_cycles = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (if4.busy_o) busy_cycles++;
    end
    total++;
    if (busy_cycles != 0) begin
      bad++;
      $display("FAIL no_auto_start got %0d busy cycles want 0", busy_cycles);
    end
  endtask
`endif

  initial begin
    if4.start_i   = 1'b0;
    if200.start_i = 1'b0;
    for (int i = 0; i < 256; i++) begin
      d4[i] = 8'd0;   e4[i] = 1'b0;
      d200[i] = 8'd0; e200[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
`ifdef TEMP_SCAN_PERIODIC_EN
    test_periodic();
`endif
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_div();
    test_wide();
`ifndef TEMP_SCAN_PERIODIC_EN
    test_no_auto_start();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
